// File: rtl/xbar_resp_core.sv
// Response crossbar: steers bank responses to the channel index each bank echoes back.
// Per-channel round-robin arbitration over banks feeding a one-entry registered output slot.
module xbar_resp_core #(
    parameter int NumBanks    = 4,
    parameter int NumChannels = 3,
    parameter int ChanWidth   = 2,
    parameter int DataWidth   = 128,
    parameter int IdWidth     = 7,
    localparam int BankW      = (NumBanks > 1) ? $clog2(NumBanks) : 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NumBanks-1:0]              d_bank_resp_valid,
    output logic [NumBanks-1:0]              d_bank_resp_ready,
    input  logic [NumBanks*ChanWidth-1:0]    d_bank_resp_chan,
    input  logic [NumBanks*DataWidth-1:0]    d_bank_resp_data,
    input  logic [NumBanks*IdWidth-1:0]      d_bank_resp_id,
    output logic [NumChannels-1:0]           u_channel_resp_valid,
    input  logic [NumChannels-1:0]           u_channel_resp_ready,
    output logic [NumChannels*DataWidth-1:0] u_channel_resp_data,
    output logic [NumChannels*IdWidth-1:0]   u_channel_resp_id,
    output logic [NumChannels*BankW-1:0]     u_channel_resp_bank,
    output logic                             resp_err
);

    logic [NumChannels-1:0]                valid_q;
    logic [NumChannels-1:0][DataWidth-1:0] data_q;
    logic [NumChannels-1:0][IdWidth-1:0]   id_q;
    logic [NumChannels-1:0][BankW-1:0]     bank_q;
    logic [NumChannels-1:0][BankW-1:0]     rr_q;
    logic [NumChannels-1:0][BankW-1:0]     rr_d;
    logic                                  resp_err_q;
    logic                                  resp_err_d;

    logic [NumChannels-1:0]                gnt_vld;
    logic [NumChannels-1:0][BankW-1:0]     gnt_idx;
    logic [NumChannels-1:0][DataWidth-1:0] gnt_data;
    logic [NumChannels-1:0][IdWidth-1:0]   gnt_id;
    logic [NumBanks-1:0]                   bank_ready;

    always_comb begin
        int unsigned chan_u;
        int unsigned idx;
        bank_ready = '0;
        resp_err_d = 1'b0;
        gnt_vld    = '0;
        gnt_idx    = '0;
        gnt_data   = '0;
        gnt_id     = '0;
        rr_d       = rr_q;
        chan_u     = 0;
        idx        = 0;

        // Out-of-range channel indices are swallowed immediately and flagged.
        for (int unsigned b = 0; b < NumBanks; b++) begin
            chan_u = 32'(d_bank_resp_chan[b*ChanWidth +: ChanWidth]);
            if (d_bank_resp_valid[b] && chan_u >= NumChannels) begin
                bank_ready[b] = 1'b1;
                resp_err_d    = 1'b1;
            end
        end

        for (int unsigned c = 0; c < NumChannels; c++) begin
            if (!valid_q[c] || u_channel_resp_ready[c]) begin
                for (int unsigned off = 0; off < NumBanks; off++) begin
                    idx    = (32'(rr_q[c]) + off) % NumBanks;
                    chan_u = 32'(d_bank_resp_chan[idx*ChanWidth +: ChanWidth]);
                    if (!gnt_vld[c] && d_bank_resp_valid[idx] && chan_u == c) begin
                        gnt_vld[c]      = 1'b1;
                        gnt_idx[c]      = BankW'(idx);
                        gnt_data[c]     = d_bank_resp_data[idx*DataWidth +: DataWidth];
                        gnt_id[c]       = d_bank_resp_id[idx*IdWidth +: IdWidth];
                        bank_ready[idx] = 1'b1;
                        rr_d[c]         = BankW'((idx + 1) % NumBanks);
                    end
                end
            end
        end

        d_bank_resp_ready = bank_ready & {NumBanks{rst_n}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= '0;
            data_q     <= '0;
            id_q       <= '0;
            bank_q     <= '0;
            rr_q       <= '0;
            resp_err_q <= 1'b0;
        end else begin
            resp_err_q <= resp_err_d;
            rr_q       <= rr_d;
            for (int unsigned c = 0; c < NumChannels; c++) begin
                if (gnt_vld[c]) begin
                    valid_q[c] <= 1'b1;
                    data_q[c]  <= gnt_data[c];
                    id_q[c]    <= gnt_id[c];
                    bank_q[c]  <= gnt_idx[c];
                end else if (u_channel_resp_ready[c]) begin
                    valid_q[c] <= 1'b0;
                end
            end
        end
    end

    assign u_channel_resp_valid = valid_q;
    assign u_channel_resp_data  = data_q;
    assign u_channel_resp_id    = id_q;
    assign u_channel_resp_bank  = bank_q;
    assign resp_err             = resp_err_q;

endmodule

// File: tb/tb_xbar_resp_core.sv
// Directed self-checking bench for xbar_resp_core with hand-computed expectations.
module tb_xbar_resp_core;

    localparam int NB = 4;
    localparam int NC = 3;
    localparam int CW = 2;
    localparam int DW = 128;
    localparam int IW = 7;
    localparam int BW = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NB-1:0]     bvalid = '0;
    logic [NB-1:0]     bready;
    logic [NB*CW-1:0]  bchan = '0;
    logic [NB*DW-1:0]  bdata = '0;
    logic [NB*IW-1:0]  bid = '0;
    logic [NC-1:0]     cvalid;
    logic [NC-1:0]     cready = '1;
    logic [NC*DW-1:0]  cdata;
    logic [NC*IW-1:0]  cid;
    logic [NC*BW-1:0]  cbank;
    logic              err;

    int ncmp = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    xbar_resp_core #(
        .NumBanks(NB), .NumChannels(NC), .ChanWidth(CW), .DataWidth(DW), .IdWidth(IW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .d_bank_resp_valid(bvalid), .d_bank_resp_ready(bready),
        .d_bank_resp_chan(bchan), .d_bank_resp_data(bdata), .d_bank_resp_id(bid),
        .u_channel_resp_valid(cvalid), .u_channel_resp_ready(cready),
        .u_channel_resp_data(cdata), .u_channel_resp_id(cid),
        .u_channel_resp_bank(cbank), .resp_err(err)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_bank(input int b, input logic v, input logic [CW-1:0] ch,
                            input logic [DW-1:0] d, input logic [IW-1:0] id);
        bvalid[b]          = v;
        bchan[b*CW +: CW]  = ch;
        bdata[b*DW +: DW]  = d;
        bid[b*IW +: IW]    = id;
    endtask

    initial begin
        logic [1:0] order [6];
        order = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3};

        // Reset state
        #2;
        chk("rst_valid", 128'(cvalid), 128'(3'b000));
        chk("rst_err",   128'(err),    128'(1'b0));
        chk("rst_ready", 128'(bready), 128'(4'b0000));
        chk("rst_data",  128'(cdata),  128'(0));
        tick();
        rst_n = 1'b1;

        // Single response: bank 2 -> channel 1
        set_bank(2, 1'b1, 2'd1, 128'hA5, 7'h11);
        #1;
        chk("single_ready", 128'(bready), 128'(4'b0100));
        tick();
        set_bank(2, 1'b0, 2'd0, '0, '0);
        #1;
        chk("single_valid", 128'(cvalid), 128'(3'b010));
        chk("single_data",  cdata[1*DW +: DW], 128'hA5);
        chk("single_id",    128'(cid[1*IW +: IW]), 128'h11);
        chk("single_bank",  128'(cbank[1*BW +: BW]), 128'd2);
        chk("single_noready", 128'(bready), 128'(4'b0000));
        tick();
        chk("single_1cyc", 128'(cvalid), 128'(3'b000));

        // Contention on channel 0 from banks 0, 1, 3
        set_bank(0, 1'b1, 2'd0, 128'h100, 7'h00);
        set_bank(1, 1'b1, 2'd0, 128'h101, 7'h01);
        set_bank(3, 1'b1, 2'd0, 128'h103, 7'h03);
        #1;
        for (int i = 0; i < 6; i++) begin
            chk("cont_ready", 128'(bready), 128'(4'b0001 << order[i]));
            tick();
            chk("cont_valid", 128'(cvalid[0]), 128'(1'b1));
            chk("cont_bank",  128'(cbank[0 +: BW]), 128'(order[i]));
            chk("cont_data",  cdata[0 +: DW], 128'h100 + 128'(order[i]));
        end
        set_bank(0, 1'b0, 2'd0, '0, '0);
        set_bank(1, 1'b0, 2'd0, '0, '0);
        set_bank(3, 1'b0, 2'd0, '0, '0);
        tick();
        chk("cont_drain", 128'(cvalid), 128'(3'b000));

        // Backpressure on channel 2
        cready[2] = 1'b0;
        set_bank(0, 1'b1, 2'd2, 128'hB0, 7'h20);
        set_bank(1, 1'b1, 2'd2, 128'hB1, 7'h21);
        #1;
        chk("bp_first_ready", 128'(bready), 128'(4'b0001));
        tick();
        set_bank(0, 1'b0, 2'd0, '0, '0);
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_ready", 128'(bready), 128'(4'b0000));
            chk("bp_hold_valid", 128'(cvalid[2]), 128'(1'b1));
            chk("bp_hold_data",  cdata[2*DW +: DW], 128'hB0);
            chk("bp_hold_bank",  128'(cbank[2*BW +: BW]), 128'd0);
            tick();
        end
        cready[2] = 1'b1;
        #1;
        chk("bp_release_ready", 128'(bready), 128'(4'b0010));
        tick();
        set_bank(1, 1'b0, 2'd0, '0, '0);
        #1;
        chk("bp_next_valid", 128'(cvalid[2]), 128'(1'b1));
        chk("bp_next_data",  cdata[2*DW +: DW], 128'hB1);
        chk("bp_next_id",    128'(cid[2*IW +: IW]), 128'h21);
        tick();
        chk("bp_drain", 128'(cvalid), 128'(3'b000));

        // Parallel channels
        set_bank(0, 1'b1, 2'd0, 128'hD0, 7'h30);
        set_bank(1, 1'b1, 2'd1, 128'hD1, 7'h31);
        set_bank(2, 1'b1, 2'd2, 128'hD2, 7'h32);
        #1;
        chk("par_ready", 128'(bready), 128'(4'b0111));
        tick();
        set_bank(0, 1'b0, 2'd0, '0, '0);
        set_bank(1, 1'b0, 2'd0, '0, '0);
        set_bank(2, 1'b0, 2'd0, '0, '0);
        #1;
        chk("par_valid", 128'(cvalid), 128'(3'b111));
        chk("par_bank",  128'(cbank), 128'(6'b10_01_00));
        chk("par_data2", cdata[2*DW +: DW], 128'hD2);
        tick();
        chk("par_drain", 128'(cvalid), 128'(3'b000));

        // Illegal channel index
        set_bank(3, 1'b1, 2'd3, 128'hEE, 7'h7F);
        #1;
        chk("ill_ready", 128'(bready), 128'(4'b1000));
        chk("ill_err_now", 128'(err), 128'(1'b0));
        tick();
        set_bank(3, 1'b0, 2'd0, '0, '0);
        #1;
        chk("ill_err", 128'(err), 128'(1'b1));
        chk("ill_novalid", 128'(cvalid), 128'(3'b000));
        tick();
        chk("ill_err_pulse", 128'(err), 128'(1'b0));

        // Reset mid-operation: pending slot discarded, rr returns to 0
        cready[0] = 1'b0;
        set_bank(2, 1'b1, 2'd0, 128'hC2, 7'h42);
        tick();
        set_bank(2, 1'b1, 2'd0, 128'hC2, 7'h42);
        set_bank(3, 1'b1, 2'd0, 128'hC3, 7'h43);
        #1;
        chk("rstm_held", 128'(cvalid[0]), 128'(1'b1));
        chk("rstm_bp_ready", 128'(bready), 128'(4'b0000));
        rst_n = 1'b0;
        #1;
        chk("rstm_valid", 128'(cvalid), 128'(3'b000));
        chk("rstm_ready", 128'(bready), 128'(4'b0000));
        tick();
        chk("rstm_ready_edge", 128'(bready), 128'(4'b0000));
        rst_n = 1'b1;
        cready[0] = 1'b1;
        #1;
        chk("rstm_first_ready", 128'(bready), 128'(4'b0100));
        tick();
        set_bank(2, 1'b0, 2'd0, '0, '0);
        #1;
        chk("rstm_first_bank", 128'(cbank[0 +: BW]), 128'd2);
        chk("rstm_first_data", cdata[0 +: DW], 128'hC2);
        chk("rstm_second_ready", 128'(bready), 128'(4'b1000));
        tick();
        set_bank(3, 1'b0, 2'd0, '0, '0);
        #1;
        chk("rstm_second_bank", 128'(cbank[0 +: BW]), 128'd3);
        tick();
        chk("rstm_drain", 128'(cvalid), 128'(3'b000));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
